mem_stage: RTL

- Memory-access stage between EXE and WB: consumes the EXE result and control signals, performs loads and stores on the data-memory bus, and produces the writeback packet for the register file.
- Non-memory ops pass through with 1-cycle latency.
- Loads/stores run a req/gnt/rvalid handshake and back-pressure EXE via ex_ready until done.
- Handles byte/half/word sizing, sign extension and misalignment detection.

---
 rtl/mem_stage_if.sv | 54 +++++
 rtl/mem_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: bundles the EXE-side handshake, the data-memory bus and the
// writeback packet of the memory-access stage.
//   ex_*     : op presented by EXE, ex_ready back-pressure
//   dmem_*   : req/gnt/rvalid data-memory bus
//   wb_*     : writeback packet to the register file
//   misalign : one-cycle misaligned-access fault pulse
// master = the stage itself, slave = the surrounding pipeline / memory.
interface mem_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
);
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_alu_y;
    logic [XLEN-1:0] ex_store_data;
    logic [REGW-1:0] ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic [2:0]      ex_funct3;

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    logic            wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [REGW-1:0] wb_rd;
    logic            wb_regwrite;
    logic            misalign;

    modport master (
        input  ex_valid, ex_alu_y, ex_store_data, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_funct3,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output ex_ready,
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_data, wb_rd, wb_regwrite, misalign
    );

    modport slave (
        output ex_valid, ex_alu_y, ex_store_data, ex_rd, ex_regwrite,
               ex_memread, ex_memwrite, ex_funct3,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  ex_ready,
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               wb_valid, wb_data, wb_rd, wb_regwrite, misalign
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE and WB. ALU ops retire one
// cycle after accept; loads/stores run a req/gnt(/rvalid) transaction on the
// data-memory bus while holding EXE off via ex_ready. Handles byte/half/word
// sizing, load sign/zero extension and misaligned-access faults.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_stage_if.master (EXE inputs, dmem bus, writeback, misalign)
module mem_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic          clk,
    input  logic          rst,
    mem_stage_if.master   bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          state_q;
    logic [1:0]      lane_q;
    logic [2:0]      funct3_q;
    logic [REGW-1:0] rd_q;
    logic            regwrite_q;
    logic            is_load_q;

    logic            dmem_req_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_wdata_q;
    logic [3:0]      dmem_wstrb_q;

    logic            wb_valid_q;
    logic [XLEN-1:0] wb_data_q;
    logic [REGW-1:0] wb_rd_q;
    logic            wb_regwrite_q;
    logic            misalign_q;

    logic            is_load_c;
    logic            is_store_c;
    logic            mem_op_c;
    logic            fault_c;
    logic            rw_c;
    logic [1:0]      lane_c;
    logic [3:0]      wstrb_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] shifted_c;
    logic [XLEN-1:0] load_c;

    // Accept-time decode: op class, alignment fault, store lanes.
    always_comb begin
        is_load_c  = bus.ex_memread;
        is_store_c = bus.ex_memwrite & ~bus.ex_memread;  // load wins if both set
        mem_op_c   = is_load_c | is_store_c;
        lane_c     = bus.ex_alu_y[1:0];
        rw_c       = bus.ex_regwrite & (bus.ex_rd != '0);
        fault_c    = 1'b0;
        wstrb_c    = 4'b1111;
        wdata_c    = bus.ex_store_data;
        case (bus.ex_funct3[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << lane_c;
                wdata_c = {4{bus.ex_store_data[7:0]}};
            end
            2'b01: begin
                fault_c = lane_c[0];
                wstrb_c = 4'b0011 << lane_c;
                wdata_c = {2{bus.ex_store_data[15:0]}};
            end
            2'b10:   fault_c = |lane_c;
            default: fault_c = 1'b1;
        endcase
        if (is_load_c && (bus.ex_funct3[2:1] == 2'b11)) begin
            fault_c = 1'b1;
        end
        if (!mem_op_c) begin
            fault_c = 1'b0;
        end
    end

    // Load lane select and extension from the captured offset/size.
    always_comb begin
        shifted_c = bus.dmem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_c = {{(XLEN-8){1'b0}}, shifted_c[7:0]};
            3'b101:  load_c = {{(XLEN-16){1'b0}}, shifted_c[15:0]};
            default: load_c = shifted_c;  // LW: lane is always 0
        endcase
    end

    // Stage FSM with registered bus and writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            lane_q        <= '0;
            funct3_q      <= '0;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            is_load_q     <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            dmem_wstrb_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ex_valid) begin
                        if (!mem_op_c) begin
                            wb_valid_q    <= 1'b1;
                            wb_data_q     <= bus.ex_alu_y;
                            wb_rd_q       <= bus.ex_rd;
                            wb_regwrite_q <= rw_c;
                        end else if (fault_c) begin
                            // Fault retires immediately with no bus traffic.
                            misalign_q    <= 1'b1;
                            wb_valid_q    <= 1'b1;
                            wb_rd_q       <= bus.ex_rd;
                            wb_regwrite_q <= 1'b0;
                        end else begin
                            lane_q       <= lane_c;
                            funct3_q     <= bus.ex_funct3;
                            rd_q         <= bus.ex_rd;
                            regwrite_q   <= rw_c;
                            is_load_q    <= is_load_c;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= is_store_c;
                            dmem_addr_q  <= {bus.ex_alu_y[XLEN-1:2], 2'b00};
                            dmem_wdata_q <= is_store_c ? wdata_c : '0;
                            dmem_wstrb_q <= is_store_c ? wstrb_c : 4'b0000;
                            state_q      <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (is_load_q) begin
                            state_q <= S_WAIT;
                        end else begin
                            wb_valid_q    <= 1'b1;
                            wb_rd_q       <= rd_q;
                            wb_regwrite_q <= 1'b0;
                            state_q       <= S_IDLE;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.dmem_rvalid) begin
                        wb_valid_q    <= 1'b1;
                        wb_data_q     <= load_c;
                        wb_rd_q       <= rd_q;
                        wb_regwrite_q <= regwrite_q;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ex_ready    = (state_q == S_IDLE);
    assign bus.dmem_req    = dmem_req_q;
    assign bus.dmem_we     = dmem_we_q;
    assign bus.dmem_addr   = dmem_addr_q;
    assign bus.dmem_wdata  = dmem_wdata_q;
    assign bus.dmem_wstrb  = dmem_wstrb_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_regwrite = wb_regwrite_q;
    assign bus.misalign    = misalign_q;
endmodule
